// File: rtl/fft_out_streamer_if.sv
// Handshake/bus bundle for fft_out_streamer: bin write port, stream output and status.
// The slave modport is the streamer's view; master is the producer/consumer side.
interface fft_out_streamer_if #(
    parameter int bit_width = 34,
    parameter int SIZE      = 5
);
    logic                        wr_en;
    logic [SIZE-1:0]             wr_addr;
    logic signed [bit_width-1:0] Re_in;
    logic signed [bit_width-1:0] Im_in;
    logic                        finish_FFT;
    logic                        out_ready;
    logic signed [bit_width-1:0] Re_out;
    logic signed [bit_width-1:0] Im_out;
    logic                        en_comp;
    logic [SIZE-1:0]             bin_idx;
    logic                        done_all;
    logic                        busy;

    modport master (
        output wr_en, wr_addr, Re_in, Im_in, finish_FFT, out_ready,
        input  Re_out, Im_out, en_comp, bin_idx, done_all, busy
    );

    modport slave (
        input  wr_en, wr_addr, Re_in, Im_in, finish_FFT, out_ready,
        output Re_out, Im_out, en_comp, bin_idx, done_all, busy
    );
endinterface

// File: rtl/fft_out_streamer.sv
// FFT result buffer and streamer: stores N complex bins, then streams them with backpressure.
// Optional macro BITREV_READ_EN selects bit-reversed read addressing.
module fft_out_streamer #(
    parameter int bit_width = 34,
    parameter int N         = 32,
    parameter int SIZE      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_out_streamer_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    localparam logic [SIZE-1:0] LAST_BIN = SIZE'(N - 1);

    logic [1:0]                  state;
    logic [SIZE-1:0]             rd_cnt;
    logic [SIZE-1:0]             rd_addr;
    logic signed [bit_width-1:0] re_mem [N];
    logic signed [bit_width-1:0] im_mem [N];
    logic signed [bit_width-1:0] re_q;
    logic signed [bit_width-1:0] im_q;
    logic [SIZE-1:0]             bin_q;
    logic                        en_q;
    logic                        done_q;
    logic                        slot_free;
    logic                        wr_ok;

`ifdef BITREV_READ_EN
    function automatic logic [SIZE-1:0] bit_reverse(input logic [SIZE-1:0] v);
        logic [SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < SIZE; i++) begin
            r[i] = v[SIZE-1-i];
        end
        return r;
    endfunction

    assign rd_addr = bit_reverse(rd_cnt);
`else
    assign rd_addr = rd_cnt;
`endif

    assign wr_ok     = bus.wr_en && (state == IDLE);
    assign slot_free = !en_q || bus.out_ready;

    // RAM contents survive reset, so the write port carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            re_mem[bus.wr_addr] <= bus.Re_in;
            im_mem[bus.wr_addr] <= bus.Im_in;
        end
    end

    // The registered RAM read doubles as the output register, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
            re_q   <= '0;
            im_q   <= '0;
            bin_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.finish_FFT) begin
                        state  <= STREAM;
                        rd_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (slot_free) begin
                        re_q   <= re_mem[rd_addr];
                        im_q   <= im_mem[rd_addr];
                        bin_q  <= rd_cnt;
                        en_q   <= 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_BIN) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Re_out   = re_q;
    assign bus.Im_out   = im_q;
    assign bus.bin_idx  = bin_q;
    assign bus.en_comp  = en_q;
    assign bus.done_all = done_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_fft_out_streamer.sv
// Scoreboard bench for fft_out_streamer: a frame-level model queues expected samples,
// a negedge monitor checks every accepted sample, stalls, latency and done_all timing.
module tb_fft_out_streamer;
    localparam int BW   = 34;
    localparam int N    = 32;
    localparam int SIZE = 5;

    typedef struct {
        int                 bin;
        logic signed [BW-1:0] re;
        logic signed [BW-1:0] im;
    } exp_t;

    logic clk;
    logic rst_n;

    fft_out_streamer_if #(.bit_width(BW), .SIZE(SIZE)) bus ();

    fft_out_streamer #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic signed [BW-1:0] model_re [N];
    logic signed [BW-1:0] model_im [N];
    exp_t exp_q[$];

    int   fin_cycle = 0;
    int   stalls    = 0;
    int   accepts   = 0;
    bit   first_seen   = 1'b1;
    bit   hold_pending = 1'b0;
    bit   exp_done     = 1'b0;
    logic signed [BW-1:0] hold_re;
    logic signed [BW-1:0] hold_im;
    logic [SIZE-1:0]      hold_bin;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // Natural bin b is read from this RAM address.
    function automatic int read_addr(input int b);
        int r;
        int v;
        r = b;
`ifdef BITREV_READ_EN
        r = 0;
        v = b;
        for (int i = 0; i < SIZE; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
`endif
        return r;
    endfunction

    function automatic logic signed [BW-1:0] rand34();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[BW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input int addr, input logic signed [BW-1:0] re,
                                  input logic signed [BW-1:0] im, input logic fin);
        bus.wr_en      = we;
        bus.wr_addr    = SIZE'(addr);
        bus.Re_in      = re;
        bus.Im_in      = im;
        bus.finish_FFT = fin;
        tick();
        bus.wr_en      = 1'b0;
        bus.finish_FFT = 1'b0;
    endtask

    task automatic write_bin(input int addr, input logic signed [BW-1:0] re, input logic signed [BW-1:0] im);
        model_re[addr] = re;
        model_im[addr] = im;
        apply_stimulus(1'b1, addr, re, im, 1'b0);
    endtask

    // Issue finish_FFT from IDLE, optionally with a simultaneous write, and queue the frame.
    task automatic start_frame(input logic we, input int addr, input logic signed [BW-1:0] re,
                               input logic signed [BW-1:0] im);
        exp_t e;
        if (we) begin
            model_re[addr] = re;
            model_im[addr] = im;
        end
        for (int b = 0; b < N; b++) begin
            e.bin = b;
            e.re  = model_re[read_addr(b)];
            e.im  = model_im[read_addr(b)];
            exp_q.push_back(e);
        end
        fin_cycle  = cycle;
        first_seen = 1'b0;
        apply_stimulus(we, addr, re, im, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.en_comp && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_output(name, 64'(ok), 64'd1);
        tick();
    endtask

    task automatic random_ready_frame(input string name);
        for (int i = 0; i < 1000; i++) begin
            tick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.busy && exp_q.size() == 0) break;
        end
        bus.out_ready = 1'b1;
        wait_idle(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_re"},   64'(bus.Re_out),   64'd0);
        check_output({tag, "_im"},   64'(bus.Im_out),   64'd0);
        check_output({tag, "_en"},   64'(bus.en_comp),  64'd0);
        check_output({tag, "_bin"},  64'(bus.bin_idx),  64'd0);
        check_output({tag, "_done"}, 64'(bus.done_all), 64'd0);
        check_output({tag, "_busy"}, 64'(bus.busy),     64'd0);
    endtask

    // Monitor: checks holds, latency, every accepted sample, and done_all placement.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pending = 1'b0;
            exp_done     = 1'b0;
        end else begin
            if (exp_done || bus.done_all) begin
                check_output("done_all", 64'(bus.done_all), 64'(exp_done));
                if (bus.done_all) begin
                    check_output("frame_accepts", 64'(accepts), 64'(N));
                    check_output("done_cycle", 64'(cycle - fin_cycle), 64'(2 + N + stalls));
                    check_output("busy_at_done", 64'(bus.busy), 64'd0);
                end
            end
            exp_done = 1'b0;
            if (hold_pending) begin
                check_output("hold_en",  64'(bus.en_comp), 64'd1);
                check_output("hold_re",  64'(bus.Re_out),  64'(hold_re));
                check_output("hold_im",  64'(bus.Im_out),  64'(hold_im));
                check_output("hold_bin", 64'(bus.bin_idx), 64'(hold_bin));
            end
            if (bus.en_comp && !first_seen) begin
                check_output("first_latency", 64'(cycle - fin_cycle), 64'd2);
                first_seen = 1'b1;
                stalls     = 0;
                accepts    = 0;
            end
            if (bus.en_comp && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_output", 64'(bus.en_comp), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("bin_idx", 64'(bus.bin_idx), 64'(e.bin));
                    check_output("re_out",  64'(bus.Re_out),  64'(e.re));
                    check_output("im_out",  64'(bus.Im_out),  64'(e.im));
                    accepts++;
                    if (e.bin == N - 1) exp_done = 1'b1;
                end
            end
            hold_pending = bus.en_comp && !bus.out_ready;
            if (hold_pending) begin
                stalls++;
                hold_re  = bus.Re_out;
                hold_im  = bus.Im_out;
                hold_bin = bus.bin_idx;
            end
        end
    end

    initial begin
        bit found;
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.Re_in      = '0;
        bus.Im_in      = '0;
        bus.finish_FFT = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle");

        $display("[TB] frame with Re=k, Im=-k");
        for (int k = 0; k < N; k++) write_bin(k, BW'(k), -BW'(k));
        start_frame(1'b0, 0, '0, '0);
        wait_idle("frame_ramp");

        $display("[TB] random data, 3-cycle stall at bin 10");
        for (int k = 0; k < N; k++) write_bin(k, rand34(), rand34());
        start_frame(1'b0, 0, '0, '0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.en_comp && bus.bin_idx == 5'd9) begin
                found = 1'b1;
                break;
            end
        end
        check_output("reach_bin9", 64'(found), 64'd1);
        tick();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        bus.out_ready = 1'b1;
        wait_idle("frame_stall");

        $display("[TB] random backpressure frame");
        start_frame(1'b0, 0, '0, '0);
        random_ready_frame("frame_random_ready");

        $display("[TB] write and finish during STREAM are ignored");
        start_frame(1'b0, 0, '0, '0);
        repeat (5) tick();
        apply_stimulus(1'b1, 5, BW'(99), BW'(7), 1'b1);
        wait_idle("frame_ignore");
        start_frame(1'b0, 0, '0, '0);
        random_ready_frame("frame_after_ignore");

        $display("[TB] reset at bin 20");
        start_frame(1'b0, 0, '0, '0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.en_comp && bus.bin_idx == 5'd20) begin
                found = 1'b1;
                break;
            end
        end
        check_output("reach_bin20", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        tick();
        start_frame(1'b0, 0, '0, '0);
        wait_idle("frame_after_reset");

        $display("[TB] write and finish in the same cycle");
        start_frame(1'b1, 31, rand34(), rand34());
        wait_idle("frame_same_cycle");

        for (int k = 0; k < N; k++) write_bin(k, rand34(), rand34());
        start_frame(1'b0, 0, '0, '0);
        random_ready_frame("frame_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
